// File: rtl/rob_commit_unit_pkg.sv
// Shared types for the ROB retire stage: ROB head payload, pointer widths and the
// commit FSM state encoding.
package rob_commit_unit_pkg;

    localparam int PREGS     = 64;
    localparam int PREG_W    = $clog2(PREGS);
    localparam int ROB_PTR_W = 4;
    localparam int ARCH_W    = 5;

    typedef struct packed {
        logic [31:0]       pc;
        logic              is_branch;
        logic              has_dest;
        logic [ARCH_W-1:0] arch_rd;
        logic [PREG_W-1:0] dest_preg;
        logic [PREG_W-1:0] old_preg;
    } rob_entry_t;

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } commit_state_e;

endpackage

// File: rtl/rob_commit_unit_free_fifo.sv
// First-word fall-through FIFO with valid/ready on both ends and an occupancy count.
// Used to buffer superseded physical registers on their way back to the free list.
module commit_free_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_in_valid,
    input  logic [WIDTH-1:0]         i_in_data,
    output logic                     o_in_ready,
    output logic                     o_out_valid,
    output logic [WIDTH-1:0]         o_out_data,
    input  logic                     i_out_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_in_ready  = (r_count != (AW+1)'(DEPTH));
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = r_mem[r_rptr];
    assign o_count     = r_count;

    assign w_push = i_in_valid && o_in_ready;
    assign w_pop  = o_out_valid && i_out_ready;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_in_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Retire stage: pops completed ROB head entries, updates the retirement RAT and returns
// superseded pregs to the free list. Optional perf counters under COMMIT_PERF_EN.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int ROB_DEPTH   = 16,
    parameter int FREEQ_DEPTH = 4,
    parameter int ARCH_REGS   = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          commit_valid_i,
    input  rob_entry_t                    commit_entry_i,
    input  logic [ROB_PTR_W-1:0]          commit_rob_index_i,
    output logic                          commit_ready_o,
    input  logic                          recover_i,
    output logic                          free_valid_o,
    output logic [PREG_W-1:0]             free_preg_o,
    input  logic                          free_ready_i,
    output logic [ARCH_REGS*PREG_W-1:0]   rrat_map_o,
    output logic                          retire_valid_o,
    output logic [31:0]                   retire_pc_o,
    output logic                          retire_is_branch_o,
    output logic                          order_err_o,
    output logic [31:0]                   retired_cnt_o,
    output logic [31:0]                   branch_cnt_o
);

    localparam int FQ_CW = $clog2(FREEQ_DEPTH) + 1;

    commit_state_e        r_state;
    logic [PREG_W-1:0]    r_rrat [ARCH_REGS];
    logic [ROB_PTR_W-1:0] r_exp_head;
    logic                 r_order_err;
    logic                 r_retire_valid;
    logic [31:0]          r_retire_pc;
    logic                 r_retire_br;

    logic [FQ_CW-1:0]     w_fq_count;
    logic                 w_fq_in_ready;
    logic                 w_fire;
    logic                 w_push;
    logic [ROB_PTR_W-1:0] w_exp_head_nxt;

    // Conservative: a full queue blocks commit even when it is popping this cycle.
    assign commit_ready_o = !rst_i && (r_state == S_RUN) && !recover_i
                            && (w_fq_count < FQ_CW'(FREEQ_DEPTH));
    assign w_fire = commit_valid_i && commit_ready_o;
    assign w_push = w_fire && commit_entry_i.has_dest
                    && (commit_entry_i.old_preg != '0) && w_fq_in_ready;

    assign w_exp_head_nxt = (r_exp_head == ROB_PTR_W'(ROB_DEPTH-1)) ? '0
                                                                     : r_exp_head + 1'b1;

    commit_free_fifo #(
        .WIDTH (PREG_W),
        .DEPTH (FREEQ_DEPTH)
    ) u_free_q (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_in_valid  (w_push),
        .i_in_data   (commit_entry_i.old_preg),
        .o_in_ready  (w_fq_in_ready),
        .o_out_valid (free_valid_o),
        .o_out_data  (free_preg_o),
        .i_out_ready (free_ready_i),
        .o_count     (w_fq_count)
    );

    // Recovery holds for exactly the cycles recover_i is high plus one bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN:     if (recover_i)  r_state <= S_RECOVER;
                S_RECOVER: if (!recover_i) r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ARCH_REGS; i++) r_rrat[i] <= PREG_W'(i);
        end else if (w_fire && commit_entry_i.has_dest && (commit_entry_i.arch_rd != '0)) begin
            r_rrat[commit_entry_i.arch_rd] <= commit_entry_i.dest_preg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exp_head     <= '0;
            r_order_err    <= 1'b0;
            r_retire_valid <= 1'b0;
            r_retire_pc    <= '0;
            r_retire_br    <= 1'b0;
        end else begin
            r_retire_valid <= w_fire;
            if (w_fire) begin
                r_retire_pc <= commit_entry_i.pc;
                r_retire_br <= commit_entry_i.is_branch;
                r_exp_head  <= w_exp_head_nxt;
                if (commit_rob_index_i != r_exp_head) r_order_err <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
        assign rrat_map_o[g*PREG_W +: PREG_W] = r_rrat[g];
    end

    assign retire_valid_o     = r_retire_valid;
    assign retire_pc_o        = r_retire_pc;
    assign retire_is_branch_o = r_retire_br;
    assign order_err_o        = r_order_err;

`ifdef COMMIT_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_branch_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retired_cnt <= '0;
            r_branch_cnt  <= '0;
        end else if (w_fire) begin
            r_retired_cnt <= r_retired_cnt + 1'b1;
            if (commit_entry_i.is_branch) r_branch_cnt <= r_branch_cnt + 1'b1;
        end
    end

    assign retired_cnt_o = r_retired_cnt;
    assign branch_cnt_o  = r_branch_cnt;
`else
    assign retired_cnt_o = '0;
    assign branch_cnt_o  = '0;
`endif

endmodule
